// File: rtl/room_pkg.sv
// Shared types and constants for the room thermal plant model.
package room_pkg;

  localparam int TEMP_W   = 5;
  localparam int TEMP_MAX = 31;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {DRIFT, HEAT, COOL, HOLD} mode_t;

  function automatic mode_t decode_mode(input logic heating, input logic cooling);
    case ({heating, cooling})
      2'b10:   return HEAT;
      2'b01:   return COOL;
      2'b11:   return HOLD;
      default: return DRIFT;
    endcase
  endfunction

endpackage

// File: rtl/room_thermal_model_step_timer.sv
// Period counter: strobes tick once every `period` enabled cycles, restart discards progress.
module step_timer
  import room_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] period,
  input  logic             restart,
  input  logic             enable,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == period - CNT_W'(1));
  assign tick   = enable & ~restart & at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !enable || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/room_thermal_model.sv
// Room temperature plant driven by heating/cooling demands.
// Optional sticky conflicting-demand flag enabled by defining ROOM_FAULT_CHECK_EN.
module room_thermal_model
  import room_pkg::*;
#(
  parameter int RISE_PERIOD  = 4,
  parameter int FALL_PERIOD  = 4,
  parameter int DRIFT_PERIOD = 16,
  parameter int AMBIENT      = 15,
  parameter int INIT_TEMP    = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              heating,
  input  logic              cooling,
  output logic [TEMP_W-1:0] temperature,
  output logic              temp_update,
  output logic              fault
);

  localparam logic [TEMP_W-1:0] AMB  = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0] TMAX = TEMP_W'(TEMP_MAX);

  mode_t             mode;
  mode_t             sampled;
  logic              restart;
  logic              enable;
  logic              tick;
  logic [CNT_W-1:0]  period;
  logic [TEMP_W-1:0] next_temp;

  assign sampled = decode_mode(heating, cooling);
  assign restart = (sampled != mode);
  assign enable  = (mode != HOLD);

  always_comb begin
    period = CNT_W'(DRIFT_PERIOD);
    case (mode)
      HEAT:    period = CNT_W'(RISE_PERIOD);
      COOL:    period = CNT_W'(FALL_PERIOD);
      default: period = CNT_W'(DRIFT_PERIOD);
    endcase
  end

  step_timer u_step_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .period  (period),
    .restart (restart),
    .enable  (enable),
    .tick    (tick)
  );

  // Saturation is explicit compares so the 5-bit value never wraps.
  always_comb begin
    next_temp = temperature;
    if (tick) begin
      case (mode)
        HEAT:    if (temperature != TMAX) next_temp = temperature + TEMP_W'(1);
        COOL:    if (temperature != '0)   next_temp = temperature - TEMP_W'(1);
        DRIFT: begin
          if (temperature < AMB)      next_temp = temperature + TEMP_W'(1);
          else if (temperature > AMB) next_temp = temperature - TEMP_W'(1);
        end
        default: next_temp = temperature;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= DRIFT;
      temperature <= TEMP_W'(INIT_TEMP);
      temp_update <= 1'b0;
    end else begin
      mode        <= sampled;
      temperature <= next_temp;
      temp_update <= (next_temp != temperature);
    end
  end

`ifdef ROOM_FAULT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (heating && cooling) begin
      fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: doc/room_thermal_model.md
# room_thermal_model

Synthesizable plant model for the air-conditioning loop. Consumes the `heating`/`cooling` demands produced by the climate monitor and drives back a 5-bit room `temperature`, closing the loop so that the monitor can be exercised in closed-loop simulation and on the board. The temperature rises while heating, falls while cooling and drifts toward an ambient value when both demands are idle, each at a parameterised cycle rate.

## Interface
- `RISE_PERIOD`, 4: cycles per +1 step while heating (≥1).
- `FALL_PERIOD`, 4: cycles per −1 step while cooling (≥1).
- `DRIFT_PERIOD`, 16: cycles per 1-step move toward ambient when idle (≥1).
- `AMBIENT`, 15: ambient temperature (0–31).
- `INIT_TEMP`, 18: temperature loaded at reset (0–31).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `heating` in 1: heating demand from the monitor.
- `cooling` in 1: cooling demand from the monitor.
- `temperature` out 5: registered room temperature, unsigned.
- `temp_update` out 1: one-cycle pulse, high in the cycle after `temperature` changed.
- `fault` out 1: sticky conflicting-demand flag (see Configuration).

## Operation
- Mode is derived from the inputs sampled at each edge:
  - `heating & ~cooling` → HEAT.
  - `cooling & ~heating` → COOL.
  - both low → DRIFT.
  - both high → HOLD (temperature frozen).
- Mode register resets to DRIFT.
- Step counter `cnt` runs 0..P−1, where P is the period of the current mode; HOLD has no period and `cnt` holds at 0.
- When `cnt == P−1` and the mode is unchanged, one step is applied and `cnt` returns to 0.
- Steps by mode:
  - HEAT: +1, saturating at 31.
  - COOL: −1, saturating at 0.
  - DRIFT: ±1 toward `AMBIENT`; no change when equal.
- A saturated or ambient-equal step leaves `temperature` unchanged; `temp_update` stays low.
- Mode change: at the edge where the sampled mode differs from the mode register, the register updates and `cnt` clears to 0. No step is taken at that edge, so partial progress is discarded.
- Reset values:
  - `temperature` = `INIT_TEMP`
  - mode = DRIFT
  - `cnt` = 0
  - `temp_update` = 0
  - `fault` = 0
- Arithmetic is done on 5 bits with explicit saturation compares; no wrap-around is permitted.

## Timing
- Inputs are sampled at every rising edge; the outputs are registered.
- Let the new mode be sampled at edge k. The first step appears at edge k+P, then at every P edges while the mode is held.
- `temp_update` goes high for exactly the one cycle following each edge that changed `temperature`.
- A mode toggle with a period shorter than P produces no steps.
- If `rst_n` is asserted mid-count, all state clears immediately. Counting resumes from 0 at the first edge after deassertion.

## Configuration
- `ROOM_FAULT_CHECK_EN` defined:
  - `fault` is set at the first edge that samples `heating & cooling`.
  - It stays set until reset.
- `ROOM_FAULT_CHECK_EN` undefined:
  - `fault` is tied to 0 and the fault logic is not compiled in.
- HOLD behaviour is the same with or without the macro.

## Structure
- Shared package `room_pkg`:
  - `TEMP_W = 5`
  - `TEMP_MAX = 31`
  - `mode_t` enum {DRIFT, HEAT, COOL, HOLD}
- One sub-module `step_timer`:
  - Contains the period counter.
  - Inputs: `period`, `restart`, `enable`.
  - Output: `tick` strobe.
  - The top module holds the mode register, the temperature datapath and the fault flag.

## Test plan
All scenarios use the default parameters unless stated.
- Reset check: reset, then release with `heating = cooling = 0` → `temperature = 18`, `temp_update = 0`, `fault = 0`.
- Drift toward ambient: hold idle for 48 cycles → 17, 16, 15 at edges 16, 32 and 48 after release, then steady at 15 with no further `temp_update`.
- Heat steps: `heating = 1` from `temperature = 18` → 19 at edge k+4 and 20 at edge k+8. Also toggle `heating` every 3 cycles → no step.
- Saturation and period switch:
  - `INIT_TEMP = 30`, heat for 12 cycles → 31, then holds with a single `temp_update` pulse.
  - Switching to `cooling` → 30 exactly 4 edges after the switch.
- Conflicting demands: assert `heating = cooling = 1` → `temperature` frozen, `fault = 1` (macro on) or `fault = 0` (macro off). `fault` remains 1 after the inputs return to 0 until `rst_n` pulses.
- Reset mid-operation: assert `rst_n` low asynchronously at `cnt = 2` in HEAT → immediate `temperature = 18`; after release the next step occurs 16 edges later in DRIFT.
